memory_stage: RTL and testbench

Memory stage of the 5-stage pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and drives data-cache load/store requests until `dhit`, buffering load data so a request is never re-issued. It also owns the MEM/WB pipeline register, which presents resolved write-back data to the register file. It exports MEM-stage forwarding information and a stall to the hazard unit.

---
 rtl/cpu_types_pkg.sv | 54 +++++
 rtl/mem_req_ctrl.sv | 67 ++++++
 rtl/memory_stage.sv | 113 +++++++++++
 tb/tb_memory_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, write-back select codes,
// MEM-stage request states and the EX/MEM and MEM/WB register bundles.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [2:0]  regsel_t;

    localparam regsel_t SEL_ALU = 3'd0;
    localparam regsel_t SEL_MEM = 3'd1;
    localparam regsel_t SEL_NPC = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HELD
    } memstate_t;

    typedef struct packed {
        word_t    alu_out;
        word_t    rtdat;
        word_t    npc;
        logic     dren;
        logic     dwen;
        logic     regwr;
        logic     halt;
        regsel_t  regsel;
        regbits_t regdst;
    } ex_mem_t;

    typedef struct packed {
        logic     regwr;
        regbits_t regdst;
        word_t    wdat;
        logic     halt;
    } mem_wb_t;

    // Unknown select codes fall back to the ALU result.
    function automatic word_t wb_select(
        input regsel_t sel,
        input word_t   alu,
        input word_t   ld,
        input word_t   npc
    );
        word_t r;
        case (sel)
            SEL_MEM: r = ld;
            SEL_NPC: r = npc;
            default: r = alu;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-cache request sequencer for the memory stage: one access per
// memory op, load data parked in ldbuf when the pipeline is held.
module mem_req_ctrl
    import cpu_types_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  em_dren_i,
    input  logic  em_dwen_i,
    input  logic  dhit_i,
    input  logic  ihit_i,
    input  logic  advance_i,
    input  logic  in_memop_i,
    input  word_t dmemload_i,
    output logic  dmemren_o,
    output logic  dmemwen_o,
    output logic  stall_o,
    output word_t ldata_o
);

    memstate_t state_q, state_d;
    memstate_t in_state;
    word_t     ldbuf_q, ldbuf_d;

    assign in_state = in_memop_i ? REQ : IDLE;

    assign dmemren_o = (state_q == REQ) & em_dren_i;
    assign dmemwen_o = (state_q == REQ) & em_dwen_i;
    assign stall_o   = (state_q == REQ) & ~dhit_i;
    assign ldata_o   = (state_q == HELD) ? ldbuf_q : dmemload_i;

    // Next state: follow the incoming op on advance, park a finished
    // access in HELD when fetch is not ready to move the pipe.
    always_comb begin
        state_d = state_q;
        ldbuf_d = ldbuf_q;
        unique case (state_q)
            IDLE: begin
                if (advance_i) state_d = in_state;
            end
            REQ: begin
                if (dhit_i && advance_i) begin
                    state_d = in_state;
                end else if (dhit_i && !ihit_i) begin
                    ldbuf_d = dmemload_i;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (advance_i) state_d = in_state;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and load buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ldbuf_q <= '0;
        end else begin
            state_q <= state_d;
            ldbuf_q <= ldbuf_d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers, data-cache
// requests, write-back select and MEM-stage forwarding info.
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        flush,
    input  logic [31:0] ex_ALUOut,
    input  logic [31:0] ex_rtdat,
    input  logic [31:0] ex_nPC,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_regWr,
    input  logic        ex_halt,
    input  logic [2:0]  ex_regSel,
    input  logic [4:0]  ex_regDst,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        fwd_regWr,
    output logic [4:0]  fwd_regDst,
    output logic [31:0] fwd_data,
    output logic        fwd_load,
    output logic        wb_regWr,
    output logic [4:0]  wb_regDst,
    output logic [31:0] wb_wdat,
    output logic        wb_halt
);

    ex_mem_t em_q, em_d;
    mem_wb_t wb_q, wb_d;
    logic    advance;
    logic    in_memop;
    word_t   ld_data;

    assign advance  = ihit & ~mem_stall;
    assign in_memop = (ex_dREN | ex_dWEN) & ~flush;

    mem_req_ctrl u_req (
        .clk_i      (CLK),
        .rst_i      (nRST),
        .em_dren_i  (em_q.dren),
        .em_dwen_i  (em_q.dwen),
        .dhit_i     (dhit),
        .ihit_i     (ihit),
        .advance_i  (advance),
        .in_memop_i (in_memop),
        .dmemload_i (dmemload),
        .dmemren_o  (dmemREN),
        .dmemwen_o  (dmemWEN),
        .stall_o    (mem_stall),
        .ldata_o    (ld_data)
    );

    // Incoming EX/MEM contents: the execute bundle, or a bubble on flush.
    always_comb begin
        em_d = '0;
        if (!flush) begin
            em_d.alu_out = ex_ALUOut;
            em_d.rtdat   = ex_rtdat;
            em_d.npc     = ex_nPC;
            em_d.dren    = ex_dREN;
            em_d.dwen    = ex_dWEN;
            em_d.regwr   = ex_regWr;
            em_d.halt    = ex_halt;
            em_d.regsel  = ex_regSel;
            em_d.regdst  = ex_regDst;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) em_q <= '0;
        else if (advance) em_q <= em_d;
    end

    // Resolve write-back data for the instruction leaving MEM.
    always_comb begin
        wb_d        = '0;
        wb_d.regwr  = em_q.regwr;
        wb_d.regdst = em_q.regdst;
        wb_d.halt   = em_q.halt;
        wb_d.wdat   = wb_select(em_q.regsel, em_q.alu_out,
                                ld_data, em_q.npc);
    end

    // MEM/WB pipeline register.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) wb_q <= '0;
        else if (advance) wb_q <= wb_d;
    end

    assign dmemaddr   = em_q.alu_out;
    assign dmemstore  = em_q.rtdat;

    assign fwd_regWr  = em_q.regwr & (em_q.regdst != '0);
    assign fwd_regDst = em_q.regdst;
    assign fwd_data   = (em_q.regsel == SEL_NPC) ? em_q.npc
                                                  : em_q.alu_out;
    assign fwd_load   = em_q.regwr & (em_q.regsel == SEL_MEM);

    assign wb_regWr   = wb_q.regwr;
    assign wb_regDst  = wb_q.regdst;
    assign wb_wdat    = wb_q.wdat;
    assign wb_halt    = wb_q.halt;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_memory_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, flush;
    logic [31:0] ex_ALUOut, ex_rtdat, ex_nPC;
    logic        ex_dREN, ex_dWEN, ex_regWr, ex_halt;
    logic [2:0]  ex_regSel;
    logic [4:0]  ex_regDst;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        mem_stall;
    logic        fwd_regWr;
    logic [4:0]  fwd_regDst;
    logic [31:0] fwd_data;
    logic        fwd_load;
    logic        wb_regWr;
    logic [4:0]  wb_regDst;
    logic [31:0] wb_wdat;
    logic        wb_halt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    memory_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush),
        .ex_ALUOut(ex_ALUOut), .ex_rtdat(ex_rtdat), .ex_nPC(ex_nPC),
        .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr),
        .ex_halt(ex_halt), .ex_regSel(ex_regSel), .ex_regDst(ex_regDst),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall),
        .fwd_regWr(fwd_regWr), .fwd_regDst(fwd_regDst),
        .fwd_data(fwd_data), .fwd_load(fwd_load),
        .wb_regWr(wb_regWr), .wb_regDst(wb_regDst),
        .wb_wdat(wb_wdat), .wb_halt(wb_halt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] rt,
                          input logic [31:0] npc, input logic ren,
                          input logic wen, input logic wr,
                          input logic [2:0] sel, input logic [4:0] dst);
        ex_ALUOut = alu; ex_rtdat = rt; ex_nPC = npc;
        ex_dREN = ren; ex_dWEN = wen; ex_regWr = wr;
        ex_halt = 1'b0; ex_regSel = sel; ex_regDst = dst;
    endtask

    task automatic nop_ex();
        set_ex(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b1;
        tick();
        tick();
        nRST = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [31:0] alu, npc, ld;
        logic [2:0]  sel;
        logic [4:0]  dst;
        logic        wr, ren, wen;
        logic        e_fwr;
        logic [31:0] e_fdata;
        logic        e_fload;
        logic [31:0] e_wdat;
        logic        e_wwr;
    } vec_t;

    vec_t vecs [6];

    typedef struct {
        logic [31:0] alu, rt, npc;
        logic        ren, wen, wr, halt;
        logic [2:0]  sel;
        logic [4:0]  dst;
    } ins_t;

    ins_t        m_em, cur;
    logic        m_done;
    logic [31:0] m_ldv;
    logic        m_wwr, m_whalt;
    logic [4:0]  m_wdst;
    logic [31:0] m_wdat;

    initial begin
        ihit = 1'b0; flush = 1'b0; dhit = 1'b0; dmemload = '0;
        nop_ex();
        nRST = 1'b1;

        // reset state
        #2;
        chk("rst_dmemREN", {31'b0, dmemREN}, 0);
        chk("rst_dmemaddr", dmemaddr, 0);
        chk("rst_stall", {31'b0, mem_stall}, 0);
        chk("rst_wb_regWr", {31'b0, wb_regWr}, 0);
        chk("rst_wb_wdat", wb_wdat, 0);
        do_reset();
        chk("postrst_fwd_regWr", {31'b0, fwd_regWr}, 0);
        chk("postrst_wb_halt", {31'b0, wb_halt}, 0);

        // vector table
        vecs[0] = '{32'h1234, 32'h8, 32'hAAAA, 3'd0, 5'd3, 1, 0, 0,
                    1, 32'h1234, 0, 32'h1234, 1};
        vecs[1] = '{32'h100, 32'h4, 32'hCAFEF00D, 3'd1, 5'd5, 1, 1, 0,
                    1, 32'h100, 1, 32'hCAFEF00D, 1};
        vecs[2] = '{32'h77, 32'h24, 32'h0, 3'd2, 5'd31, 1, 0, 0,
                    1, 32'h24, 0, 32'h24, 1};
        vecs[3] = '{32'h55AA, 32'h10, 32'h3, 3'd5, 5'd7, 1, 0, 0,
                    1, 32'h55AA, 0, 32'h55AA, 1};
        vecs[4] = '{32'h200, 32'h0, 32'h11, 3'd1, 5'd0, 1, 1, 0,
                    0, 32'h200, 1, 32'h11, 1};
        vecs[5] = '{32'h40, 32'h0, 32'h99, 3'd1, 5'd9, 0, 0, 1,
                    0, 32'h40, 0, 32'h99, 0};
        ihit = 1'b1;
        dhit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_ex(vecs[i].alu, 32'h0, vecs[i].npc, vecs[i].ren,
                   vecs[i].wen, vecs[i].wr, vecs[i].sel, vecs[i].dst);
            dmemload = vecs[i].ld;
            tick();
            chk($sformatf("v%0d_fwd_regWr", i), {31'b0, fwd_regWr},
                {31'b0, vecs[i].e_fwr});
            chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_fdata);
            chk($sformatf("v%0d_fwd_load", i), {31'b0, fwd_load},
                {31'b0, vecs[i].e_fload});
            nop_ex();
            tick();
            chk($sformatf("v%0d_wb_wdat", i), wb_wdat, vecs[i].e_wdat);
            chk($sformatf("v%0d_wb_regWr", i), {31'b0, wb_regWr},
                {31'b0, vecs[i].e_wwr});
        end

        // load with three stall cycles
        dhit = 1'b0;
        set_ex(32'h100, 32'h0, 32'h4, 1, 0, 1, 3'd1, 5'd4);
        tick();
        nop_ex();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ld3_stall_c%0d", k), {31'b0, mem_stall}, 1);
            chk($sformatf("ld3_addr_c%0d", k), dmemaddr, 32'h100);
            chk($sformatf("ld3_ren_c%0d", k), {31'b0, dmemREN}, 1);
            tick();
        end
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
        #1;
        chk("ld3_stall_hit", {31'b0, mem_stall}, 0);
        tick();
        chk("ld3_wb_wdat", wb_wdat, 32'hDEADBEEF);
        chk("ld3_wb_regWr", {31'b0, wb_regWr}, 1);
        chk("ld3_wb_regDst", {27'b0, wb_regDst}, 4);
        dhit = 1'b0;

        // store, single write pulse
        set_ex(32'h40, 32'h55, 32'h0, 0, 1, 0, 3'd0, 5'd0);
        tick();
        nop_ex();
        chk("st_wen", {31'b0, dmemWEN}, 1);
        chk("st_store", dmemstore, 32'h55);
        chk("st_addr", dmemaddr, 32'h40);
        chk("st_stall", {31'b0, mem_stall}, 1);
        ihit = 1'b0;
        dhit = 1'b1;
        tick();
        chk("st_held_wen0", {31'b0, dmemWEN}, 0);
        tick();
        chk("st_held_wen1", {31'b0, dmemWEN}, 0);
        chk("st_held_stall", {31'b0, mem_stall}, 0);
        ihit = 1'b1;
        dhit = 1'b0;
        tick();
        chk("st_wb_regWr", {31'b0, wb_regWr}, 0);
        chk("st_after_wen", {31'b0, dmemWEN}, 0);

        // load completes while fetch stalls
        set_ex(32'h300, 32'h0, 32'h0, 1, 0, 1, 3'd1, 5'd6);
        tick();
        nop_ex();
        ihit = 1'b0;
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
        tick();
        dhit = 1'b0;
        dmemload = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("held_ren_c%0d", k), {31'b0, dmemREN}, 0);
            chk($sformatf("held_stall_c%0d", k), {31'b0, mem_stall}, 0);
            tick();
        end
        ihit = 1'b1;
        tick();
        chk("held_wb_wdat", wb_wdat, 32'hDEADBEEF);
        chk("held_wb_regDst", {27'b0, wb_regDst}, 6);

        // reset mid-access
        set_ex(32'h80, 32'h0, 32'h0, 1, 0, 1, 3'd1, 5'd2);
        dhit = 1'b0;
        tick();
        nop_ex();
        chk("rstmid_ren_before", {31'b0, dmemREN}, 1);
        #2;
        nRST = 1'b1;
        #1;
        chk("rstmid_ren", {31'b0, dmemREN}, 0);
        chk("rstmid_stall", {31'b0, mem_stall}, 0);
        chk("rstmid_wb_regWr", {31'b0, wb_regWr}, 0);
        chk("rstmid_wb_wdat", wb_wdat, 0);
        tick();
        nRST = 1'b0;
        #1;

        // flush while a load is stalled
        set_ex(32'h500, 32'h0, 32'h0, 1, 0, 1, 3'd1, 5'd8);
        tick();
        set_ex(32'h9, 32'h0, 32'h0, 0, 0, 1, 3'd0, 5'd10);
        flush = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("fl_stall_c%0d", k), {31'b0, mem_stall}, 1);
            tick();
        end
        dhit = 1'b1;
        dmemload = 32'h12345678;
        tick();
        chk("fl_wb_regWr_ld", {31'b0, wb_regWr}, 1);
        chk("fl_wb_wdat_ld", wb_wdat, 32'h12345678);
        chk("fl_fwd_regWr", {31'b0, fwd_regWr}, 0);
        chk("fl_ren", {31'b0, dmemREN}, 0);
        flush = 1'b0;
        dhit = 1'b0;
        nop_ex();
        tick();
        chk("fl_wb_regWr_bubble", {31'b0, wb_regWr}, 0);

        // randomized run against the reference model
        do_reset();
        m_em = '{default: 0};
        m_done = 0; m_ldv = 0;
        m_wwr = 0; m_wdst = 0; m_wdat = 0; m_whalt = 0;
        for (int n = 0; n < 2000; n++) begin
            logic        memop, req, stl, adv;
            logic [31:0] ldv, fdat;
            ihit = ($urandom_range(0, 3) != 0);
            dhit = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 7) == 0);
            dmemload = $urandom;
            cur.alu = $urandom; cur.rt = $urandom; cur.npc = $urandom;
            cur.ren = ($urandom_range(0, 2) == 0);
            cur.wen = !cur.ren && ($urandom_range(0, 3) == 0);
            cur.wr = $urandom_range(0, 1);
            cur.halt = ($urandom_range(0, 15) == 0);
            cur.sel = 3'($urandom_range(0, 7));
            cur.dst = 5'($urandom_range(0, 31));
            ex_ALUOut = cur.alu; ex_rtdat = cur.rt; ex_nPC = cur.npc;
            ex_dREN = cur.ren; ex_dWEN = cur.wen; ex_regWr = cur.wr;
            ex_halt = cur.halt; ex_regSel = cur.sel; ex_regDst = cur.dst;
            #1;
            memop = m_em.ren | m_em.wen;
            req = memop & ~m_done;
            stl = req & ~dhit;
            adv = ihit & ~stl;
            ldv = m_done ? m_ldv : dmemload;
            fdat = (m_em.sel == 3'd2) ? m_em.npc : m_em.alu;
            chk("rnd_ren", {31'b0, dmemREN}, {31'b0, req & m_em.ren});
            chk("rnd_wen", {31'b0, dmemWEN}, {31'b0, req & m_em.wen});
            chk("rnd_addr", dmemaddr, m_em.alu);
            chk("rnd_store", dmemstore, m_em.rt);
            chk("rnd_stall", {31'b0, mem_stall}, {31'b0, stl});
            chk("rnd_fwd_regWr", {31'b0, fwd_regWr},
                {31'b0, m_em.wr && m_em.dst != 0});
            chk("rnd_fwd_regDst", {27'b0, fwd_regDst}, {27'b0, m_em.dst});
            chk("rnd_fwd_data", fwd_data, fdat);
            chk("rnd_fwd_load", {31'b0, fwd_load},
                {31'b0, m_em.wr && m_em.sel == 3'd1});
            chk("rnd_wb_regWr", {31'b0, wb_regWr}, {31'b0, m_wwr});
            chk("rnd_wb_regDst", {27'b0, wb_regDst}, {27'b0, m_wdst});
            chk("rnd_wb_wdat", wb_wdat, m_wdat);
            chk("rnd_wb_halt", {31'b0, wb_halt}, {31'b0, m_whalt});
            @(posedge CLK);
            if (adv) begin
                m_wwr = m_em.wr;
                m_wdst = m_em.dst;
                m_whalt = m_em.halt;
                m_wdat = (m_em.sel == 3'd1) ? ldv : fdat;
                if (flush) m_em = '{default: 0};
                else m_em = cur;
                m_done = 0;
            end else if (req && dhit) begin
                m_done = 1;
                m_ldv = dmemload;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
